// File: rtl/montgomery_pkg.sv
// Shared types and elaboration-time parameter checks for the Montgomery multiplier.
package montgomery_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_LOOP = 3'd2,
        ST_SUB  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic bit digits_legal(input int digits);
        return (digits == 1) || (digits == 2) || (digits == 4);
    endfunction

    function automatic bit width_legal(input int width, input int digits);
        return (width >= 8) && ((width % digits) == 0);
    endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: C' = (C + a_i*B + q*M) / 2, q chosen to make the sum even.
module mont_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] c_in,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH+1:0] bm,
    output logic [WIDTH+1:0] c_out
);

    logic             odd;
    logic [WIDTH+1:0] addend;
    logic [WIDTH+1:0] sum;

    always_comb begin
        // Parity after the optional B add decides whether M is folded in.
        odd = c_in[0] ^ (a_bit & b[0]);
        case ({a_bit, odd})
            2'b11:   addend = bm;
            2'b10:   addend = {2'b00, b};
            2'b01:   addend = {2'b00, m};
            default: addend = '0;
        endcase
        sum   = c_in + addend;
        c_out = {1'b0, sum[WIDTH+1:1]};
    end

endmodule

// File: rtl/montgomery_param.sv
// Iterative Montgomery multiplier: result = A*B*2^-WIDTH mod M, DIGITS radix-2 steps per clock.
module montgomery_param
    import montgomery_pkg::*;
#(
    parameter int WIDTH  = 1024,
    parameter int DIGITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int ITERS = WIDTH / DIGITS;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam int ACC_W = WIDTH + 2;

    if (!digits_legal(DIGITS) || !width_legal(WIDTH, DIGITS)) begin : g_param_check
        $error("montgomery_param: illegal WIDTH/DIGITS combination");
    end

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [ACC_W-1:0]   bm_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [ACC_W-1:0]   loop_acc;
    logic [ACC_W-1:0]   sub_diff;
    logic               sub_ge;
    logic               handshake;
    logic               loop_last;

    assign handshake = in_valid & in_ready;
    assign loop_last = (cnt_reg == CNT_W'(ITERS - 1));
    assign sub_diff  = acc_reg - {2'b00, m_reg};
    assign sub_ge    = (acc_reg >= {2'b00, m_reg});

    // Stage gi consumes a_reg[gi]; the LSB of A is processed first.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_step
        logic [ACC_W-1:0] c_i;
        logic [ACC_W-1:0] c_o;
        if (gi == 0) begin : g_first
            assign c_i = acc_reg;
        end else begin : g_next
            assign c_i = g_step[gi-1].c_o;
        end
        mont_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .c_in  (c_i),
            .a_bit (a_reg[gi]),
            .b     (b_reg),
            .m     (m_reg),
            .bm    (bm_reg),
            .c_out (c_o)
        );
    end
    assign loop_acc = g_step[DIGITS-1].c_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (handshake)  state_next = ST_LOAD;
            ST_LOAD:                 state_next = ST_LOOP;
            ST_LOOP: if (loop_last)  state_next = ST_SUB;
            ST_SUB:                  state_next = ST_DONE;
            ST_DONE: if (out_ready)  state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        busy      = (state_reg != ST_IDLE);
        out_valid = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            m_reg      <= '0;
            bm_reg     <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (handshake) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        m_reg <= in_m;
                    end
                end
                ST_LOAD: begin
                    bm_reg  <= {2'b00, b_reg} + {2'b00, m_reg};
                    acc_reg <= '0;
                    cnt_reg <= '0;
                end
                ST_LOOP: begin
                    acc_reg <= loop_acc;
                    a_reg   <= a_reg >> DIGITS;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                ST_SUB: begin
                    // Accumulator is below 2M here, so one conditional subtract lands in [0, M).
                    if (sub_ge) begin
                        acc_reg    <= sub_diff;
                        result_reg <= sub_diff[WIDTH-1:0];
                    end else begin
                        result_reg <= acc_reg[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_reg;

endmodule
